// File: rtl/diff_vector_sequencer.sv
// Differential test sequencer: replays a loaded table of input vectors into two
// builds of a datapath and tracks first mismatch plus a MISR signature of build A.
module diff_vector_sequencer #(
  parameter int VEC_W  = 85,
  parameter int Y_W    = 192,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [VEC_W-1:0] cfg_wdata,
  input  logic [AW:0]      cfg_count,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_out,
  input  logic [Y_W-1:0]   y_a,
  input  logic [Y_W-1:0]   y_b,
  output logic             mismatch,
  output logic [AW-1:0]    mism_idx,
  output logic [31:0]      sig,
  output logic [2:0]       dbg_state
);

  // Run handshake: start is taken only in the cycle the block is idle (busy=0);
  // it is a request, not a level. Completion is the single-cycle done pulse,
  // after which sig/mismatch/mism_idx/vec_out stay stable until the next start.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t           r_state;
  state_t           w_next;
  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [VEC_W-1:0] r_vec;
  logic [AW:0]      r_cnt;
  logic [AW-1:0]    r_idx;
  logic [3:0]       r_settle;
  logic [31:0]      r_sig;
  logic             r_mismatch;
  logic [AW-1:0]    r_mism_idx;

  logic             w_start;
  logic             w_last;
  logic [31:0]      w_fold;
  logic [31:0]      w_sig_next;

  assign w_start = (r_state == S_IDLE) && start;
  assign w_last  = ({1'b0, r_idx} == (r_cnt - CNT_ONE));

  always_comb begin
    w_fold = '0;
    for (int k = 0; k < Y_W / 32; k++) begin
      w_fold = w_fold ^ y_a[k*32 +: 32];
    end
  end

  // x^32 + x^22 + x^2 + x + 1 shift, then fold in the compressed output word
  assign w_sig_next = {r_sig[30:0], r_sig[31] ^ r_sig[21] ^ r_sig[1] ^ r_sig[0]} ^ w_fold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (cfg_count == '0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        w_next = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      end
      S_WAIT: begin
        if (r_settle == 4'd1) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_next = w_last ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Table has no reset; writes land only while idle, including the start cycle
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && cfg_we) begin
      r_mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_settle   <= '0;
      r_sig      <= 32'hFFFF_FFFF;
      r_mismatch <= 1'b0;
      r_mism_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt      <= cfg_count;
            r_idx      <= '0;
            r_sig      <= 32'hFFFF_FFFF;
            r_mismatch <= 1'b0;
            r_mism_idx <= '0;
          end
        end
        S_APPLY: begin
          r_vec    <= r_mem[r_idx];
          r_settle <= SETTLE_V;
        end
        S_WAIT: begin
          r_settle <= r_settle - 4'd1;
        end
        S_SAMPLE: begin
          r_sig <= w_sig_next;
          if ((y_a != y_b) && !r_mismatch) begin
            r_mismatch <= 1'b1;
            r_mism_idx <= r_idx;
          end
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign vec_out   = r_vec;
  assign mismatch  = r_mismatch;
  assign mism_idx  = r_mism_idx;
  assign sig       = r_sig;
  assign dbg_state = r_state;

endmodule

// File: doc/diff_vector_sequencer.md
# diff_vector_sequencer

Sequencer that drives the fuzz-generated `top` datapath for differential checking. Software loads a table of packed input vectors. On `start`, the block applies each vector to the shared DUT input bus, waits a programmable settle time, and samples the outputs of two builds of the same design (`y_a`, `y_b`). It reports the first mismatch and a 32-bit MISR signature of `y_a`, replacing the fixed `#10` stimulus schedule with a clocked, repeatable controller.

## Interface
Parameters:
- `VEC_W`, 85: packed input width, {wire0[18:0], wire1[15:0], wire2[19:0], wire3[20:0], wire4[8:0]}
- `Y_W`, 192: DUT output width; must be a multiple of 32
- `DEPTH`, 32: vector table entries
- `AW`, 5: address width, log2(DEPTH)
- `SETTLE`, 2: cycles between applying a vector and sampling; range 0..15

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cfg_we` in 1: table write strobe; ignored while `busy`
- `cfg_addr` in AW: table write address
- `cfg_wdata` in VEC_W: table write data
- `cfg_count` in AW+1: number of vectors to run, 0..DEPTH; sampled on accepted `start`
- `start` in 1: run request; accepted only in IDLE
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `vec_out` out VEC_W: drives the DUT input bus
- `y_a` in Y_W: output of DUT build A
- `y_b` in Y_W: output of DUT build B
- `mismatch` out 1: sticky flag, set when any sample has `y_a != y_b`
- `mism_idx` out AW: index of the first mismatching vector
- `sig` out 32: MISR signature

## Operation
- States: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE
  - `cfg_we` writes `cfg_wdata` into `mem[cfg_addr]`.
  - On `start`: latch `cfg_count` into `cnt`; clear `idx`, `mismatch` and `mism_idx`; load `sig` with 32'hFFFFFFFF.
  - Next state is APPLY, or DONE if `cnt==0`.
- APPLY: load `vec_out` with `mem[idx]`; load the settle counter with SETTLE. Next state is WAIT, or SAMPLE if SETTLE==0.
- WAIT: decrement the counter. Move to SAMPLE when it reaches 1.
- SAMPLE
  - fold = XOR of the Y_W/32 32-bit words of `y_a`.
  - `sig` ← {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold (polynomial x^32+x^22+x^2+x+1).
  - If `y_a != y_b` and `mismatch==0`: set `mismatch`, `mism_idx` ← `idx`.
  - If `idx==cnt-1`, go to DONE; else `idx++` and go to APPLY.
- DONE: `done`=1 for this single cycle; return to IDLE.
- `busy`=1 in every state except IDLE.
- `vec_out`, `sig`, `mismatch` and `mism_idx` hold after the run, until the next accepted `start` or `rst`.
- `start` while busy: ignored.
- `cfg_we` while busy: ignored, table unchanged.
- `cfg_we` and `start` in the same IDLE cycle: the write happens and the run starts; the new entry is visible to the run.

## Timing
- Reset values (one edge with `rst`=1):
  - state IDLE; `busy` 0, `done` 0
  - `vec_out` 0; `sig` 32'hFFFFFFFF
  - `mismatch` 0, `mism_idx` 0
  - table contents not reset
- `rst` mid-run aborts immediately: all outputs take reset values on that edge.
- `start` accepted at edge T gives `busy`=1 from T+1.
- `vec_out` changes on the edge leaving APPLY.
- `y_a`/`y_b` are sampled at the edge leaving SAMPLE, SETTLE+1 cycles after `vec_out` changed.
- Per-vector cost: SETTLE+2 cycles.
- Run of N≥1 vectors:
  - `done` is high in cycle T+1+N·(SETTLE+2)
  - `busy` falls in the following cycle
- N=0: `done` at T+1; `sig` stays 32'hFFFFFFFF.
- `sig`, `mismatch` and `mism_idx` are final when `done` is high.

## Test plan
- Reset: assert `rst` mid-run with SETTLE=2, N=5 -> next cycle `busy`=0, `vec_out`=0, `sig`=FFFFFFFF, `mismatch`=0; the next `start` runs normally.
- Single vector: N=1, `mem[0]`=85'h1F, `y_a`=`y_b`=0 -> `vec_out`=85'h1F, `sig`=32'hFFFFFFFE, `mismatch`=0, `done` at T+1+(SETTLE+2).
- Mismatch capture: N=8, model forces `y_b=y_a^1` for vectors 3 and 6 -> `mismatch`=1, `mism_idx`=3.
- Full table / boundary:
  - N=32 with SETTLE=0 -> 64 busy cycles before `done`; last `vec_out`=`mem[31]`; `idx` never wraps.
  - N=0 -> `done` at T+1 and `sig` unchanged.
- Busy protection: `cfg_we` to address 2 and a second `start` during a run -> `mem[2]` unchanged and run length unchanged; verify by rerun and compare with a golden MISR model.
- Same-cycle write+start with N=1, `cfg_addr`=0 -> applied vector equals the new `cfg_wdata`.
